// File: rtl/quant_seq_ctrl.sv
// quant_seq_ctrl: walks a layer through the 8-lane int8 requantizer.
// Loads per-group {mult,shift,zero_point} from a small table, issues beats
// only while the output FIFO is guaranteed to have room for them, holds the
// quantizer parameters until every beat of the group has come back, and packs
// the 8x8b results into a 64b first-word-fall-through FIFO.
module quant_seq_ctrl #(
  parameter int Q_LAT      = 6,
  parameter int FIFO_DEPTH = 16,
  parameter int GRP_AW     = 4
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              cfg_we,
  input  logic [GRP_AW-1:0] cfg_addr,
  input  logic [30:0]       cfg_data,
  input  logic              start,
  input  logic [GRP_AW:0]   num_grp,
  input  logic [15:0]       grp_beats,
  output logic              busy,
  output logic              done,
  input  logic [255:0]      s_data,
  input  logic              s_vld,
  output logic              s_rdy,
  output logic [255:0]      q_data,
  output logic              q_vld,
  output logic [14:0]       q_mult,
  output logic [7:0]        q_shift,
  output logic [7:0]        q_zp,
  input  logic [63:0]       q_res,
  input  logic              q_res_vld,
  output logic [63:0]       m_data,
  output logic              m_vld,
  input  logic              m_rdy,
  output logic              err_ovf
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  // A beat is counted from its issue edge until its result is written, i.e.
  // Q_LAT+1 cycles, and the FIFO credit rule also caps it at FIFO_DEPTH.
  localparam int IF_MAX = (Q_LAT + 1 < FIFO_DEPTH) ? Q_LAT + 1 : FIFO_DEPTH;
  localparam int IF_W   = $clog2(IF_MAX + 1);
  localparam int SUM_W  = CNT_W + 1;
  localparam int NTBL   = 2 ** GRP_AW;

  localparam logic [GRP_AW:0] NG_MAX  = (GRP_AW + 1)'(NTBL);
  localparam logic [GRP_AW:0] GRP_ONE = (GRP_AW + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [IF_W-1:0] IF_ONE = IF_W'(1);
  localparam logic [SUM_W-1:0] SUM_LIM = SUM_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [30:0]       tbl_q [NTBL];
  logic [GRP_AW:0]   ngrp_q, ngrp_d;
  logic [15:0]       nbeats_q, nbeats_d;
  logic [GRP_AW:0]   grp_idx_q, grp_idx_d;
  logic [15:0]       beat_cnt_q, beat_cnt_d;
  logic [30:0]       prm_q, prm_d;
  logic [255:0]      q_data_q, q_data_d;
  logic              q_vld_q, q_vld_d;
  logic [IF_W-1:0]   inflight_q, inflight_d;

  logic [63:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic              err_ovf_q, err_ovf_d;

  logic              layer_empty;
  logic [GRP_AW:0]   grp_nxt;
  logic [SUM_W-1:0]  credit_sum;
  logic              fire;
  logic              res_dec;
  logic              fifo_full;
  logic              push;
  logic              pop;

  assign layer_empty = (ngrp_q == '0) || (nbeats_q == '0);
  assign grp_nxt     = grp_idx_q + GRP_ONE;
  // Beats already issued still need a FIFO slot, so they count against space.
  assign credit_sum  = SUM_W'(fifo_cnt_q) + SUM_W'(inflight_q);
  assign s_rdy       = (state_q == S_RUN) && (credit_sum < SUM_LIM);
  assign fire        = s_vld && s_rdy;
  // Guarded so a stray result with nothing outstanding cannot wrap the count.
  assign res_dec     = q_res_vld && (inflight_q != '0);

  assign busy = ((state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DRAIN))
                && !layer_empty;
  assign done = (state_q == S_DONE);

  assign q_data  = q_data_q;
  assign q_vld   = q_vld_q;
  assign q_mult  = prm_q[30:16];
  assign q_shift = prm_q[15:8];
  assign q_zp    = prm_q[7:0];

  assign fifo_full = (fifo_cnt_q == CNT_FULL);
  assign m_vld     = (fifo_cnt_q != '0);
  assign m_data    = m_vld ? mem_q[rd_ptr_q] : '0;
  assign pop       = m_vld && m_rdy;
  assign push      = q_res_vld && (!fifo_full || pop);
  assign err_ovf   = err_ovf_q;

  // Parameter table: plain registers, writable only between layers.
  always_ff @(posedge sclk) begin
    if (cfg_we && !busy) begin
      tbl_q[cfg_addr] <= cfg_data;
    end
  end

  // FIFO storage; contents are qualified by the count, so no reset needed.
  always_ff @(posedge sclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= q_res;
    end
  end

  // Sequencer next-state: layer walk, parameter load and beat issue.
  always_comb begin
    state_d    = state_q;
    ngrp_d     = ngrp_q;
    nbeats_d   = nbeats_q;
    grp_idx_d  = grp_idx_q;
    beat_cnt_d = beat_cnt_q;
    prm_d      = prm_q;
    q_data_d   = q_data_q;
    q_vld_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ngrp_d    = (num_grp > NG_MAX) ? NG_MAX : num_grp;
          nbeats_d  = grp_beats;
          grp_idx_d = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (layer_empty) begin
          state_d = S_DONE;
        end else begin
          prm_d      = tbl_q[grp_idx_q[GRP_AW-1:0]];
          beat_cnt_d = '0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (fire) begin
          q_data_d   = s_data;
          q_vld_d    = 1'b1;
          beat_cnt_d = beat_cnt_q + 16'd1;
          if (beat_cnt_q == nbeats_q - 16'd1) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Parameters may only move once the whole group is out of the quantizer.
        if (inflight_q == '0) begin
          grp_idx_d = grp_nxt;
          state_d   = (grp_nxt < ngrp_q) ? S_LOAD : S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // In-flight count and FIFO pointer/count/overflow next-state.
  always_comb begin
    inflight_d = inflight_q;
    if (fire && !res_dec) begin
      inflight_d = inflight_q + IF_ONE;
    end else if (!fire && res_dec) begin
      inflight_d = inflight_q - IF_ONE;
    end
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + CNT_ONE;
    end else if (pop && !push) begin
      fifo_cnt_d = fifo_cnt_q - CNT_ONE;
    end
    err_ovf_d = err_ovf_q || (q_res_vld && fifo_full && !pop);
  end

  // State registers; everything visible on the ports clears on reset.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q    <= S_IDLE;
      ngrp_q     <= '0;
      nbeats_q   <= '0;
      grp_idx_q  <= '0;
      beat_cnt_q <= '0;
      prm_q      <= '0;
      q_data_q   <= '0;
      q_vld_q    <= 1'b0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ngrp_q     <= ngrp_d;
      nbeats_q   <= nbeats_d;
      grp_idx_q  <= grp_idx_d;
      beat_cnt_q <= beat_cnt_d;
      prm_q      <= prm_d;
      q_data_q   <= q_data_d;
      q_vld_q    <= q_vld_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

endmodule

// File: tb/tb_quant_seq_ctrl.sv
// Bench for quant_seq_ctrl: a fixed-latency requantizer model closes the loop,
// and a word-level reference (beat k of a layer uses table[k / grp_beats])
// predicts every output word.
module tb_quant_seq_ctrl;

  localparam int Q_LAT = 6;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          sclk = 1'b0;
  logic          s_rst_n;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [30:0]   cfg_data;
  logic          start;
  logic [AW:0]   num_grp;
  logic [15:0]   grp_beats;
  logic          busy, done;
  logic [255:0]  s_data;
  logic          s_vld, s_rdy;
  logic [255:0]  q_data;
  logic          q_vld;
  logic [14:0]   q_mult;
  logic [7:0]    q_shift, q_zp;
  logic [63:0]   q_res;
  logic          q_res_vld;
  logic [63:0]   m_data;
  logic          m_vld, m_rdy;
  logic          err_ovf;

  quant_seq_ctrl #(.Q_LAT(Q_LAT), .FIFO_DEPTH(DEPTH), .GRP_AW(AW)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .num_grp(num_grp), .grp_beats(grp_beats),
    .busy(busy), .done(done), .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
    .q_data(q_data), .q_vld(q_vld), .q_mult(q_mult), .q_shift(q_shift), .q_zp(q_zp),
    .q_res(q_res), .q_res_vld(q_res_vld), .m_data(m_data), .m_vld(m_vld),
    .m_rdy(m_rdy), .err_ovf(err_ovf)
  );

  always #5 sclk = ~sclk;

  function automatic logic [63:0] qfun(logic [255:0] d, logic [14:0] m,
                                       logic [7:0] sh, logic [7:0] zp);
    logic [63:0] r;
    longint x, p;
    r = '0;
    for (int n = 0; n < 8; n++) begin
      x = longint'($signed(d[32*n +: 32]));
      p = x * longint'(m);
      p = p >>> sh[5:0];
      p = p + longint'($signed(zp));
      if (p > 127) p = 127;
      if (p < -128) p = -128;
      r[8*n +: 8] = p[7:0];
    end
    return r;
  endfunction

  // Requantizer model: Q_LAT-deep pipe, cleared with the shared reset.
  logic        pv [Q_LAT];
  logic [63:0] pd [Q_LAT];
  logic        fq_vld = 1'b0;
  logic [63:0] fq_data = '0;

  always @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int i = 0; i < Q_LAT; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= q_vld;
      pd[0] <= qfun(q_data, q_mult, q_shift, q_zp);
      for (int i = 1; i < Q_LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign q_res_vld = pv[Q_LAT-1] | fq_vld;
  assign q_res     = fq_vld ? fq_data : pd[Q_LAT-1];

  int          vec = 0;
  int          err = 0;
  int          cyc = 0;
  int          acc_cnt, pop_cnt, done_cnt, done_cyc, cur_beats;
  int          mult_chg, last_qvld_cyc, min_gap, start_cyc;
  bit          busy_seen, qvld_seen, pend;
  int          src_pct = 0;
  int          snk_pct = 0;
  logic [14:0] prev_mult;
  logic [63:0] expq[$];
  logic [30:0] tbl [16];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rbeat();
    logic [255:0] b;
    int v;
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 3) == 0) v = int'($urandom);
      else v = int'($urandom_range(0, 4095)) - 2048;
      b[32*n +: 32] = v;
    end
    return b;
  endfunction

  // One clock: drive at negedge, observe handshakes just before the next edge.
  task automatic cycle();
    int g;
    @(negedge sclk);
    if (!pend) begin
      s_vld = ($urandom_range(0, 99) < src_pct);
      if (s_vld) s_data = rbeat();
    end
    m_rdy = (snk_pct >= 100) ? 1'b1 : (snk_pct == 0) ? 1'b0 : ($urandom_range(0, 99) < snk_pct);
    #1;
    if (s_vld && s_rdy) begin
      g = (acc_cnt / cur_beats) % 16;
      expq.push_back(qfun(s_data, tbl[g][30:16], tbl[g][15:8], tbl[g][7:0]));
      acc_cnt++;
      pend = 1'b0;
    end else begin
      pend = s_vld;
    end
    if (m_vld && m_rdy) begin
      if (expq.size() == 0) chk("unexpected_word", m_data, 64'hx);
      else chk("word", m_data, expq.pop_front());
      pop_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_seen = 1'b1;
    if (q_vld) begin
      qvld_seen = 1'b1;
      last_qvld_cyc = cyc;
    end
    if (q_mult !== prev_mult) begin
      if (qvld_seen) begin
        mult_chg++;
        if (cyc - last_qvld_cyc < min_gap) min_gap = cyc - last_qvld_cyc;
      end
      prev_mult = q_mult;
    end
    cyc++;
    @(posedge sclk);
    #1;
  endtask

  task automatic start_layer(input int ng, input int nb);
    num_grp   = (AW + 1)'(ng);
    grp_beats = 16'(nb);
    start     = 1'b1;
    cur_beats = (nb == 0) ? 1 : nb;
    acc_cnt = 0; pop_cnt = 0; done_cnt = 0; done_cyc = -1;
    busy_seen = 0; qvld_seen = 0; mult_chg = 0; min_gap = 1000000;
    last_qvld_cyc = -1000; prev_mult = q_mult; start_cyc = cyc;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_done_reached"}, (done_cnt != 0), 1);
    pend = 1'b0;
    s_vld = 1'b0;
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    snk_pct = 100;
    while ((expq.size() != 0 || m_vld) && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_drained"}, expq.size(), 0);
  endtask

  task automatic cfg_write(input int a, input logic [30:0] d);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = d;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_s_rdy"}, s_rdy, 0);
    chk({tag, "_q_vld"}, q_vld, 0);
    chk({tag, "_q_data"}, q_data, 0);
    chk({tag, "_q_prm"}, {q_mult, q_shift, q_zp}, 0);
    chk({tag, "_m_vld"}, m_vld, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_err_ovf"}, err_ovf, 0);
  endtask

  initial begin
    s_rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
    num_grp = '0; grp_beats = '0; s_data = '0; s_vld = 1'b0; m_rdy = 1'b0;
    pend = 1'b0; cur_beats = 1; acc_cnt = 0; pop_cnt = 0; done_cnt = 0;
    prev_mult = '0; qvld_seen = 0; last_qvld_cyc = -1000; min_gap = 1000000;
    repeat (3) cycle();
    check_all_zero("reset");
    @(negedge sclk);
    s_rst_n = 1'b1;
    @(posedge sclk); #1;

    // Parameter table
    tbl[0] = {15'd16384, 8'd15, 8'd0};
    tbl[1] = {15'd8192, 8'd14, 8'd3};
    for (int i = 2; i < 16; i++)
      tbl[i] = {15'($urandom_range(1, 32767)), 8'($urandom_range(8, 20)), 8'($urandom)};
    for (int i = 0; i < 16; i++) cfg_write(i, tbl[i]);

    // 1: two groups of four beats
    src_pct = 70; snk_pct = 100;
    start_layer(2, 4);
    run_until_done(200, "t1");
    chk("t1_busy_after_done", busy, 0);
    chk("t1_busy_seen", busy_seen, 1);
    drain(100, "t1");
    chk("t1_words", pop_cnt, 8);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_mult_changes", mult_chg, 1);
    chk("t1_param_gap_ok", (min_gap >= Q_LAT), 1);

    // 2: output stalled, credit limit
    src_pct = 100; snk_pct = 0;
    start_layer(1, 40);
    repeat (60) cycle();
    chk("t2_accepted_stalled", acc_cnt, DEPTH);
    chk("t2_s_rdy_low", s_rdy, 0);
    chk("t2_m_vld", m_vld, 1);
    chk("t2_err_ovf", err_ovf, 0);
    chk("t2_no_pops", pop_cnt, 0);
    snk_pct = 100;
    run_until_done(300, "t2");
    drain(100, "t2");
    chk("t2_words", pop_cnt, 40);
    chk("t2_done_cnt", done_cnt, 1);

    // 3: start and table write while busy are ignored
    src_pct = 60; snk_pct = 50;
    start_layer(3, 5);
    repeat (4) cycle();
    chk("t3_busy_mid", busy, 1);
    num_grp = 5'd1; grp_beats = 16'd2; start = 1'b1;
    cfg_we = 1'b1; cfg_addr = '0; cfg_data = ~tbl[0];
    cycle();
    start = 1'b0; cfg_we = 1'b0;
    run_until_done(400, "t3");
    drain(200, "t3");
    chk("t3_accepted", acc_cnt, 15);
    chk("t3_words", pop_cnt, 15);
    chk("t3_done_cnt", done_cnt, 1);

    // 4: empty layers and group-count saturation
    src_pct = 100; snk_pct = 100;
    start_layer(0, 7);
    repeat (4) cycle();
    pend = 1'b0; s_vld = 1'b0;
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_done_cycle", done_cyc, start_cyc + 2);
    chk("t4_busy_never", busy_seen, 0);
    chk("t4_qvld_never", qvld_seen, 0);
    start_layer(3, 0);
    repeat (4) cycle();
    pend = 1'b0; s_vld = 1'b0;
    chk("t4b_done_cnt", done_cnt, 1);
    chk("t4b_busy_never", busy_seen, 0);
    chk("t4b_accepted", acc_cnt, 0);
    src_pct = 80;
    start_layer(20, 1);
    run_until_done(600, "t4c");
    drain(100, "t4c");
    chk("t4c_saturated_groups", acc_cnt, 16);
    chk("t4c_words", pop_cnt, 16);

    // 5: reset with beats in flight
    src_pct = 100; snk_pct = 100;
    start_layer(1, 20);
    begin
      int n = 0;
      while (acc_cnt < 5 && n < 30) begin
        cycle();
        n++;
      end
    end
    chk("t5_inflight_reached", acc_cnt, 5);
    s_rst_n = 1'b0;
    #1;
    check_all_zero("t5_async_reset");
    expq.delete();
    pend = 1'b0; s_vld = 1'b0;
    @(negedge sclk);
    s_rst_n = 1'b1;
    @(posedge sclk); #1;
    start_layer(2, 3);
    run_until_done(200, "t5");
    drain(100, "t5");
    chk("t5_words", pop_cnt, 6);
    chk("t5_done_cnt", done_cnt, 1);

    // 6: forced result into a full FIFO
    src_pct = 100; snk_pct = 0;
    start_layer(1, 16);
    run_until_done(200, "t6");
    chk("t6_accepted", acc_cnt, 16);
    chk("t6_err_before", err_ovf, 0);
    fq_data = {$urandom, $urandom};
    fq_vld = 1'b1;
    @(posedge sclk); #1;
    fq_vld = 1'b0;
    chk("t6_err_set", err_ovf, 1);
    drain(100, "t6");
    chk("t6_words_intact", pop_cnt, 16);
    chk("t6_err_sticky", err_ovf, 1);
    s_rst_n = 1'b0;
    #1;
    chk("t6_err_cleared", err_ovf, 0);
    @(negedge sclk);
    s_rst_n = 1'b1;
    @(posedge sclk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
